// File: rtl/conv_unit.sv
// conv_unit: pipelined WebAssembly reinterpret / wrap / integer-extend conversion unit.
// A trapping op drains the older results ahead of it, is reported, and then halts the unit until reset.

module conv_unit #(
    parameter bit         HAS_FPU     = 1'b1,
    parameter bit         USE_64B     = 1'b1,
    parameter int         PIPE_STAGES = 2,
    parameter logic [3:0] TRAP_BADOP  = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_op,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [1:0]  out_type,
    output logic [3:0]  out_trap,
    output logic        halted
);

    localparam logic [1:0] TY_I32      = 2'd0;
    localparam logic [1:0] TY_I64      = 2'd1;
    localparam logic [1:0] TY_F32      = 2'd2;
    localparam logic [1:0] TY_F64      = 2'd3;
    localparam logic [3:0] TRAP_NO_FPU = 4'h1;
    localparam logic [3:0] TRAP_NO_64B = 4'h2;
    localparam int         LAST        = PIPE_STAGES - 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   rdy_en_q, rdy_en_d;
    logic [PIPE_STAGES-1:0] vld_q, vld_d, adv_s;
    logic [63:0]            data_q [PIPE_STAGES];
    logic [63:0]            data_d [PIPE_STAGES];
    logic [1:0]             type_q [PIPE_STAGES];
    logic [1:0]             type_d [PIPE_STAGES];
    logic [3:0]             trap_q [PIPE_STAGES];
    logic [3:0]             trap_d [PIPE_STAGES];

    logic        dec_sup_s, dec_flt_s, dec_64_s;
    logic [63:0] dec_res_s, dec_data_s;
    logic [1:0]  dec_ty_s, dec_type_s;
    logic [3:0]  dec_trap_s;
    logic        adv_c_s, accept_s;

    // Opcode decode: result, result type, capability class and trap code of the incoming op.
    always_comb begin
        dec_sup_s = 1'b1;
        dec_flt_s = 1'b0;
        dec_64_s  = 1'b0;
        dec_res_s = 64'd0;
        dec_ty_s  = TY_I32;
        case (in_op)
            8'hA7: begin dec_64_s = 1'b1; dec_res_s = {32'd0, in_data[31:0]}; dec_ty_s = TY_I32; end
            8'hAC: begin dec_64_s = 1'b1; dec_res_s = {{32{in_data[31]}}, in_data[31:0]}; dec_ty_s = TY_I64; end
            8'hAD: begin dec_64_s = 1'b1; dec_res_s = {32'd0, in_data[31:0]}; dec_ty_s = TY_I64; end
            8'hBC: begin dec_flt_s = 1'b1; dec_res_s = {32'd0, in_data[31:0]}; dec_ty_s = TY_I32; end
            8'hBD: begin dec_flt_s = 1'b1; dec_64_s = 1'b1; dec_res_s = in_data; dec_ty_s = TY_I64; end
            8'hBE: begin dec_flt_s = 1'b1; dec_res_s = {32'd0, in_data[31:0]}; dec_ty_s = TY_F32; end
            8'hBF: begin dec_flt_s = 1'b1; dec_64_s = 1'b1; dec_res_s = in_data; dec_ty_s = TY_F64; end
            8'hC0: begin dec_res_s = {32'd0, {24{in_data[7]}}, in_data[7:0]}; dec_ty_s = TY_I32; end
            8'hC1: begin dec_res_s = {32'd0, {16{in_data[15]}}, in_data[15:0]}; dec_ty_s = TY_I32; end
            8'hC2: begin dec_64_s = 1'b1; dec_res_s = {{56{in_data[7]}}, in_data[7:0]}; dec_ty_s = TY_I64; end
            8'hC3: begin dec_64_s = 1'b1; dec_res_s = {{48{in_data[15]}}, in_data[15:0]}; dec_ty_s = TY_I64; end
            8'hC4: begin dec_64_s = 1'b1; dec_res_s = {{32{in_data[31]}}, in_data[31:0]}; dec_ty_s = TY_I64; end
            default: dec_sup_s = 1'b0;
        endcase
        if (!dec_sup_s) begin
            dec_trap_s = TRAP_BADOP;
        end else if (dec_flt_s && !HAS_FPU) begin
            dec_trap_s = TRAP_NO_FPU;
        end else if (dec_64_s && !USE_64B) begin
            dec_trap_s = TRAP_NO_64B;
        end else begin
            dec_trap_s = 4'd0;
        end
        // A trapping op carries a zero i32 payload so the consumer never sees partial data.
        if (dec_trap_s != 4'd0) begin
            dec_data_s = 64'd0;
            dec_type_s = TY_I32;
        end else begin
            dec_data_s = dec_res_s;
            dec_type_s = dec_ty_s;
        end
    end

    // Advance chain: a stage may move when the stage after it is empty or itself moving.
    always_comb begin
        adv_s       = '0;
        adv_c_s     = !vld_q[LAST] || out_ready;
        adv_s[LAST] = adv_c_s;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv_c_s  = !vld_q[k] || adv_c_s;
            adv_s[k] = adv_c_s;
        end
    end

    assign in_ready = rdy_en_q && (state_q == ST_RUN) && adv_s[0];
    assign accept_s = in_valid && in_ready;

    // Pipeline next state: payloads only move with a valid op, so an emptied output stage keeps its trap.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        type_d = type_q;
        trap_d = trap_q;
        if (adv_s[0]) begin
            vld_d[0] = accept_s;
            if (accept_s) begin
                data_d[0] = dec_data_s;
                type_d[0] = dec_type_s;
                trap_d[0] = dec_trap_s;
            end else begin
                data_d[0] = data_q[0];
            end
        end else begin
            vld_d[0] = vld_q[0];
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (adv_s[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    type_d[k] = type_q[k-1];
                    trap_d[k] = trap_q[k-1];
                end else begin
                    data_d[k] = data_q[k];
                end
            end else begin
                vld_d[k] = vld_q[k];
            end
        end
    end

    // Control FSM: RUN until a trap is accepted, DRAIN until it leaves, then HALT until reset.
    always_comb begin
        state_d  = state_q;
        rdy_en_d = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (accept_s && (dec_trap_s != 4'd0)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (vld_q[LAST] && out_ready && (trap_q[LAST] != 4'd0)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // State and pipeline registers; reset discards every in-flight op immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            rdy_en_q <= 1'b0;
            vld_q    <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= 64'd0;
                type_q[k] <= TY_I32;
                trap_q[k] <= 4'd0;
            end
        end else begin
            state_q  <= state_d;
            rdy_en_q <= rdy_en_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            type_q   <= type_d;
            trap_q   <= trap_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_type  = type_q[LAST];
    assign out_trap  = trap_q[LAST];
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_conv_unit.sv
// Self-checking bench for conv_unit: scoreboard on the default-parameter unit,
// directed capability-trap checks on USE_64B=0 and HAS_FPU=0 instances.

module tb_conv_unit;

    localparam int         PS        = 2;
    localparam logic [1:0] TY_I32    = 2'd0;
    localparam logic [1:0] TY_I64    = 2'd1;
    localparam logic [1:0] TY_F32    = 2'd2;
    localparam logic [1:0] TY_F64    = 2'd3;
    localparam logic [3:0] TR_BAD    = 4'hF;
    localparam logic [3:0] TR_NO_FPU = 4'h1;
    localparam logic [3:0] TR_NO_64B = 4'h2;
    localparam logic [63:0] D        = 64'hFEDC_BA98_7654_8321;
    localparam logic [63:0] DX       = 64'h0000_0000_8000_0080;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, halted;
    logic [7:0]  in_op;
    logic [63:0] in_data, out_data;
    logic [1:0]  out_type;
    logic [3:0]  out_trap;

    logic        xv, x_ordy;
    logic [7:0]  x_op1, x_op2;
    logic [63:0] x_data;
    logic        rdy1, ov1, h1, rdy2, ov2, h2;
    logic [63:0] od1, od2;
    logic [1:0]  ot1, ot2;
    logic [3:0]  otr1, otr2;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  t;
        logic [3:0]  tr;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0, n_err = 0, cyc = 0, n_push = 0, n_pop = 0;
    bit   chk_lat = 1'b0;

    always #5 clk = ~clk;

    conv_unit #(.HAS_FPU(1'b1), .USE_64B(1'b1), .PIPE_STAGES(PS), .TRAP_BADOP(TR_BAD)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_type(out_type), .out_trap(out_trap), .halted(halted));

    conv_unit #(.HAS_FPU(1'b1), .USE_64B(1'b0), .PIPE_STAGES(PS), .TRAP_BADOP(TR_BAD)) u_dut_no64 (
        .clk(clk), .reset(reset), .in_valid(xv), .in_ready(rdy1), .in_op(x_op1),
        .in_data(x_data), .out_valid(ov1), .out_ready(x_ordy), .out_data(od1),
        .out_type(ot1), .out_trap(otr1), .halted(h1));

    conv_unit #(.HAS_FPU(1'b0), .USE_64B(1'b1), .PIPE_STAGES(PS), .TRAP_BADOP(TR_BAD)) u_dut_nofpu (
        .clk(clk), .reset(reset), .in_valid(xv), .in_ready(rdy2), .in_op(x_op2),
        .in_data(x_data), .out_valid(ov2), .out_ready(x_ordy), .out_data(od2),
        .out_type(ot2), .out_trap(otr2), .halted(h2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops on a handshake, and checks held values while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else if (out_ready) begin
                e = sb_q.pop_front();
                n_pop++;
                chk("out_data", out_data, e.d);
                chk("out_type", 64'(out_type), 64'(e.t));
                chk("out_trap", 64'(out_trap), 64'(e.tr));
                if (chk_lat) chk("latency", 64'(cyc - e.acc), 64'(PS));
            end else begin
                chk("stall_data", out_data, sb_q[0].d);
                chk("stall_type", 64'(out_type), 64'(sb_q[0].t));
            end
        end
    end

    task automatic flush_sb();
        n_push = n_push - sb_q.size();
        sb_q.delete();
    endtask

    task automatic send(input logic [7:0] op, input logic [63:0] d,
                        input logic [63:0] ed, input logic [1:0] et, input logic [3:0] etr);
        exp_t e;
        bit   done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = ed; e.t = et; e.tr = etr; e.acc = cyc;
                sb_q.push_back(e);
                n_push++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accepted", 64'(done), 64'd1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        xv       = 1'b0;
        flush_sb();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        reset = 1'b1; in_valid = 1'b0; in_op = 8'h00; in_data = 64'd0; out_ready = 1'b1;
        xv = 1'b0; x_op1 = 8'h00; x_op2 = 8'h00; x_data = 64'd0; x_ordy = 1'b1;

        // Reset state
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_type", 64'(out_type), 64'(TY_I32));
        chk("rst_out_trap", 64'(out_trap), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_in_ready_no64", 64'(rdy1), 64'd1);

        // Capability traps: USE_64B=0 with 0xBD and HAS_FPU=0 with 0xBE, each behind a legal 0xC0
        @(posedge clk);
        #1 xv = 1'b1; x_op1 = 8'hC0; x_op2 = 8'hC0; x_data = 64'h80;
        @(negedge clk);
        chk("cap_rdy1_a", 64'(rdy1), 64'd1);
        chk("cap_rdy2_a", 64'(rdy2), 64'd1);
        @(posedge clk);
        #1 x_op1 = 8'hBD; x_op2 = 8'hBE;
        @(negedge clk);
        chk("cap_rdy1_b", 64'(rdy1), 64'd1);
        @(posedge clk);
        #1 x_op1 = 8'hC0; x_op2 = 8'hC0;
        @(negedge clk);
        chk("cap_drain_rdy1", 64'(rdy1), 64'd0);
        chk("cap_old_valid", 64'(ov1), 64'd1);
        chk("cap_old_data", od1, 64'h0000_0000_FFFF_FF80);
        chk("cap_old_trap1", 64'(otr1), 64'd0);
        chk("cap_old_trap2", 64'(otr2), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("no64_valid", 64'(ov1), 64'd1);
        chk("no64_trap", 64'(otr1), 64'(TR_NO_64B));
        chk("no64_data", od1, 64'd0);
        chk("no64_type", 64'(ot1), 64'(TY_I32));
        chk("nofpu_trap", 64'(otr2), 64'(TR_NO_FPU));
        chk("nofpu_data", od2, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("no64_halted", 64'(h1), 64'd1);
        chk("nofpu_halted", 64'(h2), 64'd1);
        chk("no64_out_valid", 64'(ov1), 64'd0);
        chk("no64_sticky", 64'(otr1), 64'(TR_NO_64B));
        repeat (3) @(negedge clk);
        chk("no64_rdy_stays0", 64'(rdy1), 64'd0);
        chk("nofpu_rdy_stays0", 64'(rdy2), 64'd0);
        @(posedge clk);
        #1 xv = 1'b0;

        // Reinterpret, then extends and the rest of the op set back-to-back
        chk_lat = 1'b1;
        send(8'hBD, 64'hC000_0000_0000_0000, 64'hC000_0000_0000_0000, TY_I64, 4'd0);
        send(8'hAC, DX, 64'hFFFF_FFFF_8000_0080, TY_I64, 4'd0);
        send(8'hAD, DX, 64'h0000_0000_8000_0080, TY_I64, 4'd0);
        send(8'hC0, DX, 64'h0000_0000_FFFF_FF80, TY_I32, 4'd0);
        send(8'hC2, DX, 64'hFFFF_FFFF_FFFF_FF80, TY_I64, 4'd0);
        send(8'hA7, D,  64'h0000_0000_7654_8321, TY_I32, 4'd0);
        send(8'hC1, D,  64'h0000_0000_FFFF_8321, TY_I32, 4'd0);
        send(8'hC3, D,  64'hFFFF_FFFF_FFFF_8321, TY_I64, 4'd0);
        send(8'hC4, D,  64'h0000_0000_7654_8321, TY_I64, 4'd0);
        send(8'hBC, D,  64'h0000_0000_7654_8321, TY_I32, 4'd0);
        send(8'hBE, D,  64'h0000_0000_7654_8321, TY_F32, 4'd0);
        send(8'hBF, D,  D, TY_F64, 4'd0);
        wait_empty();

        // Backpressure: six ops against a stalled consumer
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(8'hBF, 64'hA5A5_5A5A_0000_0000 + 64'(i), 64'hA5A5_5A5A_0000_0000 + 64'(i), TY_F64, 4'd0);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_empty();

        // Reset with two ops in flight, then a fresh op
        chk_lat = 1'b1;
        send(8'hBF, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, TY_F64, 4'd0);
        send(8'hBF, 64'h5555_6666_7777_8888, 64'h5555_6666_7777_8888, TY_F64, 4'd0);
        reset = 1'b0;
        flush_sb();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        send(8'hBF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, TY_F64, 4'd0);
        wait_empty();

        // Drain: A completes, B traps, C is never accepted
        send(8'hA7, D, 64'h0000_0000_7654_8321, TY_I32, 4'd0);
        send(8'hFF, D, 64'd0, TY_I32, TR_BAD);
        in_valid = 1'b1;
        in_op    = 8'hBC;
        acc      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acc = acc | in_ready;
        end
        chk("drain_c_blocked", 64'(acc), 64'd0);
        chk("drain_halted", 64'(halted), 64'd1);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_sticky_trap", 64'(out_trap), 64'(TR_BAD));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_empty();

        // Reset leaves HALT; opcode 0x00 is unsupported
        do_reset();
        chk("unhalt_halted", 64'(halted), 64'd0);
        chk("unhalt_in_ready", 64'(in_ready), 64'd1);
        send(8'h00, D, 64'd0, TY_I32, TR_BAD);
        wait_empty();
        @(negedge clk);
        chk("badop_halted", 64'(halted), 64'd1);
        chk("push_pop", 64'(n_pop), 64'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
